// File: rtl/sara.sv
// Segmented approximate/reconfigurable adder: size-bit sum built from exact
// group_size-bit groups whose inter-group carries are ripple or speculated.
module sara_group #(
   parameter int group_size = 4
) (
   input  logic [group_size-1:0] a,
   input  logic [group_size-1:0] b,
   input  logic                  ci,
   output logic [group_size-1:0] s,
   output logic                  co
);
   assign {co, s} = a + b + {{group_size{1'b0}}, ci};
endmodule

module sara #(
   parameter int size       = 16,
   parameter int group_size = 4,
   localparam int G         = size / group_size
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [size:1]   a,
   input  logic [size:1]   b,
   input  logic            cin,
   input  logic [G:1]      select,
   output logic [size:1]   sum,
   output logic            cout
);
   logic [G:1]                 ci;
   logic [G:1]                 c;
   logic [G:1][group_size-1:0] gs;

   // Group 1 always takes cin, so its select bit carries no meaning.
   logic unused_sel;
   assign unused_sel = select[1];
   assign ci[1] = cin;

   for (genvar k = 1; k <= G; k++) begin : g_grp
      if (k > 1) begin : g_ci
         // Speculated carry is the generate bit of the lower group's MSB.
         assign ci[k] = select[k] ? c[k-1]
                                  : (a[(k-1)*group_size] & b[(k-1)*group_size]);
      end
      sara_group #(.group_size(group_size)) u_grp (
         .a  (a[k*group_size -: group_size]),
         .b  (b[k*group_size -: group_size]),
         .ci (ci[k]),
         .s  (gs[k]),
         .co (c[k])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum  <= '0;
         cout <= 1'b0;
      end else begin
         sum  <= gs;
         cout <= c[G];
      end
   end
endmodule

// File: tb/tb_sara.sv
// Directed and randomised checks of sara against a per-group reference model.
module tb_sara;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [16:1] a = '0, b = '0;
   logic        cin = 1'b0;
   logic [4:1]  select = '0;
   logic [16:1] sum;
   logic        cout;

   int total = 0;
   int bad   = 0;

   sara #(.size(16), .group_size(4)) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin),
      .select(select), .sum(sum), .cout(cout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got cout=%0b sum=%h, want cout=%0b sum=%h",
                  tag, obs[16], obs[15:0], exp[16], exp[15:0]);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [16:0] ref_add(input logic [15:0] x, input logic [15:0] y,
                                           input logic ci0, input logic [3:0] sel);
      logic [15:0] s;
      logic [4:0]  t;
      logic        ci, cprev;
      s = '0;
      cprev = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k == 0) ci = ci0;
         else if (sel[k]) ci = cprev;
         else ci = x[4*k-1] & y[4*k-1];
         t = {1'b0, x[4*k +: 4]} + {1'b0, y[4*k +: 4]} + {4'b0, ci};
         s[4*k +: 4] = t[3:0];
         cprev = t[4];
      end
      return {cprev, s};
   endfunction

   task automatic vec(input string tag, input logic [15:0] va, input logic [15:0] vb,
                      input logic vc, input logic [3:0] vs, input logic [16:0] exp);
      a = va; b = vb; cin = vc; select = vs;
      cyc();
      chk(tag, {cout, sum}, exp);
   endtask

   initial begin
      a = 16'hFFFF; b = 16'h1234; cin = 1'b1; select = 4'hF;
      #1 chk("rst_async", {cout, sum}, 17'h0);
      repeat (3) cyc();
      chk("rst_hold", {cout, sum}, 17'h0);
      a = '0; b = '0; cin = 1'b0; select = '0;
      rst_n = 1'b1;
      cyc();
      chk("rst_release", {cout, sum}, 17'h0);

      vec("approx_err",   16'h01E8, 16'h011F, 1'b1, 4'b0000, {1'b0, 16'h0208});
      vec("exact_ref",    16'h01E8, 16'h011F, 1'b1, 4'b1111, {1'b0, 16'h0308});
      vec("approx_ok",    16'hF1E0, 16'hF000, 1'b1, 4'b0000, {1'b1, 16'hE1E1});
      vec("approx_ok_ex", 16'hF1E0, 16'hF000, 1'b1, 4'b1111, {1'b1, 16'hE1E1});
      vec("mixed_0100",   16'h01E8, 16'h011F, 1'b1, 4'b0100, {1'b0, 16'h0308});
      vec("mixed_1010",   16'h01E8, 16'h011F, 1'b1, 4'b1010, {1'b0, 16'h0208});
      vec("wrap_exact",   16'hFFFF, 16'h0000, 1'b1, 4'b1111, {1'b1, 16'h0000});
      vec("wrap_approx",  16'hFFFF, 16'h0000, 1'b1, 4'b0000, {1'b0, 16'hFFF0});
      vec("sel1_ignored", 16'hFFFF, 16'h0000, 1'b1, 4'b0001, {1'b0, 16'hFFF0});
      vec("max_exact",    16'hFFFF, 16'hFFFF, 1'b1, 4'b1111, {1'b1, 16'hFFFF});

      // Inputs changed between edges must not reach the outputs early.
      a = 16'h1111; b = 16'h2222; cin = 1'b0; select = 4'hF;
      #2 chk("no_early", {cout, sum}, {1'b1, 16'hFFFF});
      cyc();
      chk("after_edge", {cout, sum}, {1'b0, 16'h3333});

      for (int i = 0; i < 300; i++) begin
         logic [16:0] e;
         a = 16'($urandom); b = 16'($urandom);
         cin = 1'($urandom); select = 4'($urandom);
         e = ref_add(a, b, cin, select);
         cyc();
         chk($sformatf("rand%0d", i), {cout, sum}, e);
      end

      vec("pre_midrst", 16'hFFFF, 16'h0000, 1'b1, 4'b0000, {1'b0, 16'hFFF0});
      #2 rst_n = 1'b0;
      #1 chk("midrst_async", {cout, sum}, 17'h0);
      cyc();
      chk("midrst_hold", {cout, sum}, 17'h0);
      rst_n = 1'b1;
      vec("post_midrst", 16'h01E8, 16'h011F, 1'b1, 4'b1111, {1'b0, 16'h0308});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sara.md
# sara

Segmented approximate/reconfigurable adder (SARA): a `size`-bit adder split into `size/group_size` carry groups. Each inter-group carry is either the exact ripple carry or a speculated carry, chosen at run time per group by `select`. It sits in datapaths that trade accuracy for shorter carry chains. The result is registered, giving one clock of latency.

## Interface
- `size`, default 16: operand and sum width in bits; must be a multiple of `group_size`.
- `group_size`, default 4: bits per carry group; G = `size/group_size` groups.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `a`  in  [size:1]  operand A, unsigned; bit 1 is the LSB.
- `b`  in  [size:1]  operand B, unsigned; bit 1 is the LSB.
- `cin`  in  1  carry into group 1.
- `select`  in  [G:1]  per-group carry mode; `select[k]` governs the carry into group k.
- `sum`  out  [size:1]  registered sum.
- `cout`  out  1  registered carry-out of group G.

## Operation
- Group k (k = 1..G) covers bits `[k*group_size : (k-1)*group_size+1]`. Group 1 holds the LSBs.
- Each group is an exact `group_size`-bit adder: group sum plus group carry-out c_k, computed from its own carry-in ci_k.
- Carry into group 1: ci_1 = `cin`. `select[1]` is ignored.
- Carry into group k > 1:
  - `select[k]`=1 (exact): ci_k = c_(k-1), the true carry-out of group k-1, computed from that group's own ci.
  - `select[k]`=0 (approximate): ci_k = `a[m] & b[m]`, where m = (k-1)*`group_size` is the MSB of group k-1. This is the generate bit of that MSB.
- With all `select` bits set to 1, the result equals the exact `a + b + cin`, mod 2^size, with cout as the true carry.
- With `select` all 0, the critical path is a single group plus one AND gate.
- `cout` = c_G, the carry-out of the top group computed from its selected ci_G.
- Operands are unsigned. No overflow flag. Upper sum bits wrap mod 2^size.
- `select` is fully dynamic: it may change every cycle with no settling or restriction.

## Timing
- The combinational result is captured on every rising `clk` edge. Latency is 1 cycle and throughput is 1 result per cycle. There is no handshake or enable.
- While `rst_n`=0, `sum`=0 and `cout`=0, taking effect immediately and independent of `clk`.
- Reset deasserted: the first capture happens on the next rising edge.
- Reset asserted mid-stream: the outputs clear at once and the in-flight result is discarded.
- Inputs changing between edges do not affect the outputs until the next edge. There are no glitches on the outputs.

## Test plan
- Reset: hold `rst_n`=0 with nonzero inputs, toggling `clk` -> `sum`=0x0000, `cout`=0. Release reset with a=b=0, cin=0 -> next edge gives `sum`=0x0000, `cout`=0.
- Approximate case with an error: a=0x01E8, b=0x011F, cin=1, select=4'b0000 -> one cycle later `sum`=0x0208, `cout`=0. The exact answer would be 0x0308.
- Exact mode, same operands: select=4'b1111 -> `sum`=0x0308, `cout`=0.
- Approximate case that happens to be exact: a=0xF1E0, b=0xF000, cin=1, select=4'b0000 -> `sum`=0xE1E1, `cout`=1. The same result is required with select=4'b1111.
- Mixed mode: a=0x01E8, b=0x011F, cin=1, select=4'b0100 (group 3 exact) -> `sum`=0x0308, `cout`=0. With select=4'b1010 -> `sum`=0x0208, `cout`=0.
- Full wrap-around: a=0xFFFF, b=0x0000, cin=1. select=4'b1111 -> `sum`=0x0000, `cout`=1. select=4'b0000 -> `sum`=0xFFF0, `cout`=0.
- Randomised check: for random a, b, cin and select, compare against a per-group reference model every cycle. Also assert reset asynchronously mid-stream -> outputs go to 0 immediately.
